// File: rtl/l1_miss_arbiter_pkg.sv
// Shared definitions for the L1 miss arbiter: FSM state encoding, requester
// ownership encoding and the grant-vector bit positions.
package l1_miss_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    // Bit positions inside the one-hot grant vector of rr_arb2.
    localparam int GNT_I_BIT = 0;
    localparam int GNT_D_BIT = 1;

endpackage

// File: rtl/l1_miss_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory handshake signals around
// the miss arbiter. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding caches and memory.
interface l1_miss_arbiter_if #(
    parameter int ADDRESS_BITS = 12,
    parameter int DATA_WIDTH   = 32
);
    logic                    i_req;
    logic [ADDRESS_BITS-1:0] i_addr;
    logic                    i_gnt;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;

    logic                    d_req;
    logic                    d_we;
    logic [ADDRESS_BITS-1:0] d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    m_req;
    logic                    m_we;
    logic [ADDRESS_BITS-1:0] m_addr;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic                    m_ready;
    logic                    m_rvalid;
    logic [DATA_WIDTH-1:0]   m_rdata;

    logic                    busy;
    logic                    proto_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  m_ready, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_addr, m_wdata, busy, proto_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output m_ready, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, busy, proto_err
    );

endinterface

// File: rtl/l1_miss_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone requester always wins, and on a tie
// the requester that was not served last wins. Purely combinational.
module rr_arb2
    import l1_miss_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  owner_t     last_owner,
    output logic [1:0] gnt
);

    // Pick at most one winner; on a tie alternate away from the last owner.
    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d) begin
            if (last_owner == OWNER_I) begin
                gnt[GNT_D_BIT] = 1'b1;
            end else begin
                gnt[GNT_I_BIT] = 1'b1;
            end
        end else if (req_i) begin
            gnt[GNT_I_BIT] = 1'b1;
        end else if (req_d) begin
            gnt[GNT_D_BIT] = 1'b1;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/l1_miss_arbiter.sv
// L1 miss arbiter: shares one main-memory port between the I-cache (reads)
// and the D-cache (reads and writebacks). One transaction is outstanding at
// a time; every output comes straight from a register.
module l1_miss_arbiter
    import l1_miss_arbiter_pkg::*;
#(
    parameter int ADDRESS_BITS = 12,
    parameter int DATA_WIDTH   = 32
) (
    input  logic               clock,
    input  logic               reset,
    l1_miss_arbiter_if.master  bus
);

    state_t                  state_r,      state_next_s;
    owner_t                  owner_r,      owner_next_s;
    owner_t                  last_owner_r, last_owner_next_s;
    logic [1:0]              grant_s;

    logic                    m_req_r,      m_req_next_s;
    logic                    m_we_r,       m_we_next_s;
    logic [ADDRESS_BITS-1:0] m_addr_r,     m_addr_next_s;
    logic [DATA_WIDTH-1:0]   m_wdata_r,    m_wdata_next_s;

    logic                    i_gnt_r,      i_gnt_next_s;
    logic                    d_gnt_r,      d_gnt_next_s;
    logic                    i_rvalid_r,   i_rvalid_next_s;
    logic                    d_rvalid_r,   d_rvalid_next_s;
    logic [DATA_WIDTH-1:0]   i_rdata_r,    i_rdata_next_s;
    logic [DATA_WIDTH-1:0]   d_rdata_r,    d_rdata_next_s;
    logic                    busy_r,       busy_next_s;
    logic                    proto_err_r,  proto_err_next_s;

    rr_arb2 u_rr_arb2 (
        .req_i      (bus.i_req),
        .req_d      (bus.d_req),
        .last_owner (last_owner_r),
        .gnt        (grant_s)
    );

    // Next-state and next-output logic; pulses default low, holding
    // registers default to their current value.
    always_comb begin
        state_next_s      = state_r;
        owner_next_s      = owner_r;
        last_owner_next_s = last_owner_r;
        m_req_next_s      = m_req_r;
        m_we_next_s       = m_we_r;
        m_addr_next_s     = m_addr_r;
        m_wdata_next_s    = m_wdata_r;
        i_gnt_next_s      = 1'b0;
        d_gnt_next_s      = 1'b0;
        i_rvalid_next_s   = 1'b0;
        d_rvalid_next_s   = 1'b0;
        i_rdata_next_s    = i_rdata_r;
        d_rdata_next_s    = d_rdata_r;

        case (state_r)
            IDLE: begin
                if (grant_s[GNT_I_BIT]) begin
                    i_gnt_next_s      = 1'b1;
                    owner_next_s      = OWNER_I;
                    last_owner_next_s = OWNER_I;
                    m_req_next_s      = 1'b1;
                    m_we_next_s       = 1'b0;
                    m_addr_next_s     = bus.i_addr;
                    m_wdata_next_s    = '0;
                    state_next_s      = ISSUE;
                end else if (grant_s[GNT_D_BIT]) begin
                    d_gnt_next_s      = 1'b1;
                    owner_next_s      = OWNER_D;
                    last_owner_next_s = OWNER_D;
                    m_req_next_s      = 1'b1;
                    m_we_next_s       = bus.d_we;
                    m_addr_next_s     = bus.d_addr;
                    m_wdata_next_s    = bus.d_wdata;
                    state_next_s      = ISSUE;
                end else begin
                    state_next_s      = IDLE;
                end
            end
            ISSUE: begin
                if (bus.m_ready) begin
                    m_req_next_s = 1'b0;
                    if (m_we_r) begin
                        // Only the D-cache writes back; completion is the
                        // acceptance itself, no data comes back.
                        d_rvalid_next_s = 1'b1;
                        state_next_s    = IDLE;
                    end else begin
                        state_next_s    = WAIT_RD;
                    end
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT_RD: begin
                if (bus.m_rvalid) begin
                    if (owner_r == OWNER_I) begin
                        i_rvalid_next_s = 1'b1;
                        i_rdata_next_s  = bus.m_rdata;
                    end else begin
                        d_rvalid_next_s = 1'b1;
                        d_rdata_next_s  = bus.m_rdata;
                    end
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_RD;
                end
            end
            default: begin
                state_next_s = IDLE;
                m_req_next_s = 1'b0;
            end
        endcase

        busy_next_s      = (state_next_s != IDLE);
        // A read return with no read pending, or an accept with no command
        // offered, is a memory-side protocol violation; remember it.
        proto_err_next_s = proto_err_r
                         | (bus.m_rvalid & (state_r != WAIT_RD))
                         | (bus.m_ready  & ~m_req_r);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_I;
            last_owner_r <= OWNER_I;
            m_req_r      <= 1'b0;
            m_we_r       <= 1'b0;
            m_addr_r     <= '0;
            m_wdata_r    <= '0;
            i_gnt_r      <= 1'b0;
            d_gnt_r      <= 1'b0;
            i_rvalid_r   <= 1'b0;
            d_rvalid_r   <= 1'b0;
            i_rdata_r    <= '0;
            d_rdata_r    <= '0;
            busy_r       <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            owner_r      <= owner_next_s;
            last_owner_r <= last_owner_next_s;
            m_req_r      <= m_req_next_s;
            m_we_r       <= m_we_next_s;
            m_addr_r     <= m_addr_next_s;
            m_wdata_r    <= m_wdata_next_s;
            i_gnt_r      <= i_gnt_next_s;
            d_gnt_r      <= d_gnt_next_s;
            i_rvalid_r   <= i_rvalid_next_s;
            d_rvalid_r   <= d_rvalid_next_s;
            i_rdata_r    <= i_rdata_next_s;
            d_rdata_r    <= d_rdata_next_s;
            busy_r       <= busy_next_s;
            proto_err_r  <= proto_err_next_s;
        end
    end

    assign bus.i_gnt     = i_gnt_r;
    assign bus.d_gnt     = d_gnt_r;
    assign bus.i_rvalid  = i_rvalid_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.m_req     = m_req_r;
    assign bus.m_we      = m_we_r;
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wdata   = m_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.proto_err = proto_err_r;

endmodule

// File: doc/l1_miss_arbiter.md
L1_MISS_ARBITER -- requirements
Module: l1_miss_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 12, main-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req in 1, i_addr in ADDRESS_BITS: I-cache miss read request.
REQ-006 SHALL have ports i_gnt out 1, i_rvalid out 1, i_rdata out DATA_WIDTH: I-cache grant and read return.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDRESS_BITS, d_wdata in DATA_WIDTH: D-cache miss read or writeback request.
REQ-008 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DATA_WIDTH: D-cache grant and completion.
REQ-009 SHALL have ports m_req out 1, m_we out 1, m_addr out ADDRESS_BITS, m_wdata out DATA_WIDTH: main-memory command.
REQ-010 SHALL have ports m_ready in 1, m_rvalid in 1, m_rdata in DATA_WIDTH: memory accept and read return.
REQ-011 SHALL have ports busy out 1 (FSM not IDLE) and proto_err out 1 (sticky protocol error).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT_RD.
REQ-013 IDLE: if any req, SHALL select winner, pulse its gnt for one cycle, register addr/we/wdata/owner, go to ISSUE.
REQ-014 Arbitration SHALL be round-robin: on simultaneous i_req and d_req, requester not served last wins; single requester always wins.
REQ-015 last_owner SHALL update only on grant; reset value I-cache, so first tie goes to D-cache.
REQ-016 ISSUE: m_req=1 with registered command held stable until m_ready=1.
REQ-017 On m_ready in ISSUE: read -> WAIT_RD; write -> IDLE and d_rvalid pulses one cycle later, d_rdata don't-care.
REQ-018 WAIT_RD: on m_rvalid, SHALL register m_rdata; owner's rvalid/rdata SHALL pulse next cycle; go to IDLE.
REQ-019 Non-owner rvalid SHALL stay 0; rdata outputs SHALL hold last returned value.
REQ-020 Requests arriving outside IDLE SHALL be ignored; requesters hold req until gnt (no queueing).
REQ-021 Minimum turnaround IDLE->IDLE SHALL be 3 cycles for a read with m_ready and m_rvalid each asserted on first opportunity; new grant permitted the cycle rvalid pulses.
REQ-022 m_rvalid outside WAIT_RD, or m_ready when m_req=0, SHALL set proto_err and be otherwise ignored.
REQ-023 i_gnt and d_gnt SHALL never be 1 together; at most one transaction outstanding.
REQ-024 Back-to-back requests from the same requester with other idle SHALL be granted each time.

Reset
REQ-025 On reset SHALL go to IDLE; m_req, m_we, gnt, rvalid, busy, proto_err = 0; m_addr, m_wdata, rdata = 0; last_owner = I.
REQ-026 Reset mid-transaction SHALL abandon it without emitting rvalid; subsequent stale m_rvalid after reset SHALL set proto_err.

Structure
REQ-027 Shared package SHALL hold FSM state encoding and owner encoding (OWNER_I, OWNER_D).
REQ-028 Round-robin selection SHALL be sub-module rr_arb2 (two requests, last_owner in, one-hot grant out, combinational).
REQ-029 All outputs SHALL be registered except m_* which are driven from registers.

Verification
REQ-030 i_req=1 addr 0x040, m_ready at once, m_rvalid 2 cycles later data 0x00500513 -> i_gnt 1 pulse, m_addr 0x040 m_we 0, i_rvalid 1 cycle after m_rvalid, i_rdata 0x00500513.
REQ-031 i_req and d_req both 1 after reset -> d_gnt first; next IDLE i_gnt; third tie d_gnt.
REQ-032 d_req d_we=1 addr 0x0B0 wdata 0xDEADBEEF, m_ready held low 5 cycles -> m_req/m_addr/m_wdata stable 5 cycles, d_rvalid pulse 1 cycle after m_ready, no i_rvalid.
REQ-033 m_rvalid pulsed in IDLE -> proto_err=1 sticky, no rvalid outputs.
REQ-034 reset asserted in WAIT_RD, then m_rvalid -> no i/d_rvalid, busy=0, proto_err=1.
REQ-035 random i/d request streams with random memory latency 0-7 -> each grant yields exactly one completion to correct owner, data matches memory model, gnts mutually exclusive.
